write_arbiter: RTL
==================

WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 The parameter list SHALL be: NUM_CH, default 4, number of requesting writer channels (2..8).
REQ-002 The parameter list SHALL be: DATA_W, default 64, width of each channel word.
REQ-003 Port clk SHALL be: input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 Port reset_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-005 Port enable SHALL be: input, 1 bit; 1 permits capture and grant, 0 freezes arbitration.
REQ-006 Port ch_write SHALL be: input, NUM_CH bits, per-channel one-cycle write strobe.
REQ-007 Port ch_data SHALL be: input, NUM_CH*DATA_W bits, channel i word in bits [i*DATA_W +: DATA_W].
REQ-008 Port fifo_full SHALL be: input, 1 bit, downstream FIFO cannot accept a word this cycle.
REQ-009 Port ovf_clr SHALL be: input, 1 bit, pulse clearing all ch_overflow bits.
REQ-010 Port out_write SHALL be: output, 1 bit, registered one-cycle write strobe to FIFO.
REQ-011 Port out_data SHALL be: output, DATA_W bits, registered word accompanying out_write.
REQ-012 Port out_chan SHALL be: output, clog2(NUM_CH) bits, index of the channel that sourced out_data.
REQ-013 Port ch_overflow SHALL be: output, NUM_CH bits, sticky per-channel drop flag.
REQ-014 Port busy SHALL be: output, 1 bit, OR of all per-channel pending flags.

Function
- REQ-015 Each channel SHALL own a one-word holding register and a pending flag.
- REQ-016 Capture: enable=1, ch_write[i]=1, pending[i]=0 -> load ch_data word i; set pending[i] next edge.
- REQ-017 Grant cycle: enable=1, fifo_full=0, at least one pending -> exactly one channel SHALL be granted.
- REQ-018 Grant output: granted word to out_data, index to out_chan, out_write=1 on the next edge; pending cleared same edge.
- REQ-019 Latency SHALL be ch_write at edge t -> pending at t+1 -> out_write high after t+2 when uncontested and not full.
- REQ-020 out_write SHALL be 0 in any cycle without a grant.
- REQ-021 out_data and out_chan SHALL hold their last values when out_write=0.
- REQ-022 Round-robin: search SHALL start at (last_grant+1) mod NUM_CH, ascending with wrap; last_grant updates on each grant.
- REQ-023 fifo_full=1 -> no grant that cycle; pending words retained; no data loss.
- REQ-024 Overflow: ch_write[i]=1 while pending[i]=1 and channel i not granted that cycle -> new word dropped, old word kept, ch_overflow[i] set.
- REQ-025 Simultaneous: ch_write[i]=1 in the cycle channel i is granted -> new word captured, pending[i] stays 1, no overflow.
- REQ-026 ovf_clr=1 and a new overflow event in the same cycle -> that bit SHALL end set; all other bits cleared.
- REQ-027 enable=0 -> no capture, no grant, out_write=0; pending words and last_grant retained for resume.

Reset
- REQ-028 reset_n=0 SHALL asynchronously clear all pending flags, out_write, out_data, out_chan, ch_overflow.
- REQ-029 reset_n=0 SHALL set last_grant to NUM_CH-1 so channel 0 is searched first.
- REQ-030 Reset mid-operation SHALL discard held words; first grant after release occurs no earlier than 2 edges after a capture.

Configuration
- REQ-031 Macro WRITE_ARB_FIXED_PRIORITY_EN defined -> lowest-index pending channel SHALL always win; last_grant unused.
- REQ-032 Macro WRITE_ARB_FIXED_PRIORITY_EN undefined -> round-robin per REQ-022.
- REQ-033 All other behaviour SHALL be identical with and without the macro.

Verification
- REQ-034 Single write: ch_write=0001, word0=0x0000_00B4_0000_0003, fifo_full=0 -> out_write pulse 2 edges later, out_data=that word, out_chan=0.
- REQ-035 All four write together, round-robin build -> grants in order 0,1,2,3 on consecutive cycles; busy falls after the 4th.
- REQ-036 Same four writes with WRITE_ARB_FIXED_PRIORITY_EN, channel 0 rewritten every 2 cycles -> channel 0 every alternate grant; channels 1-3 served only in gaps.
- REQ-037 fifo_full=1 for 10 cycles with channels 1,2 pending -> no out_write; after release channel 1 then 2 with original data.
- REQ-038 Channel 3 written twice 1 cycle apart while fifo_full=1 -> ch_overflow=1000, first word delivered; ovf_clr -> 0000.
- REQ-039 reset_n pulsed low mid-burst with 3 pending -> outputs 0 immediately, no further out_write, next grant starts at channel 0.

Source files
------------

// File: rtl/write_arbiter.sv
// write_arbiter: per-channel one-word buffers arbitrated onto a single FIFO write port.
// Round-robin by default; define WRITE_ARB_FIXED_PRIORITY_EN for fixed priority (channel 0 highest).
module write_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic                       fifo_full,
    input  logic                       ovf_clr,
    output logic                       out_write,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0]  out_chan,
    output logic [NUM_CH-1:0]          ch_overflow,
    output logic                       busy
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0] pend_q, pend_d, ovf_q, ovf_d, gnt, cap, ovf_ev;
    logic [DATA_W-1:0] hold_q [NUM_CH];
    logic [CW-1:0]     gidx, out_chan_q;
    logic [DATA_W-1:0] out_data_q;
    logic              gnt_v, out_write_q;

`ifdef WRITE_ARB_FIXED_PRIORITY_EN
    always_comb begin
        gidx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (pend_q[k]) gidx = CW'(k);
    end
`else
    logic [CW-1:0] last_q, cand;
    logic          found;

    // Search starts one past the last winner and wraps, so every channel waits at most NUM_CH-1 grants.
    always_comb begin
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CW'((int'(last_q) + k) % NUM_CH);
            if (!found && pend_q[cand]) begin
                gidx  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_q <= CW'(NUM_CH - 1);
        else if (gnt_v)
            last_q <= gidx;
    end
`endif

    // A channel being granted this cycle frees its slot, so a coincident write is accepted, not dropped.
    always_comb begin
        gnt_v  = enable && !fifo_full && (|pend_q);
        gnt    = gnt_v ? (NUM_CH'(1) << gidx) : '0;
        cap    = {NUM_CH{enable}} & ch_write & (~pend_q | gnt);
        ovf_ev = {NUM_CH{enable}} & ch_write & pend_q & ~gnt;
        pend_d = cap | (pend_q & ~gnt);
        ovf_d  = (ovf_clr ? '0 : ovf_q) | ovf_ev;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= '0;
            ovf_q       <= '0;
            out_write_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            out_write_q <= gnt_v;
            if (gnt_v) begin
                out_data_q <= hold_q[gidx];
                out_chan_q <= gidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (cap[i]) hold_q[i] <= ch_data[i*DATA_W +: DATA_W];
    end

    assign out_write   = out_write_q;
    assign out_data    = out_data_q;
    assign out_chan    = out_chan_q;
    assign ch_overflow = ovf_q;
    assign busy        = |pend_q;
endmodule
